// File: rtl/step_clock_ctrl_pkg.sv
// step_ctrl_pkg: shared types and defaults for the step clock controller.
//   step_state_t  : STEP-mode FSM states (IDLE, PRESSED, REPEAT)
//   DEF_*         : default parameter values (100 MHz board clock)
//   cnt_width()   : counter width needed to hold 0..n-1 (minimum 1 bit)
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } step_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_RUN_DIV         = 50000000;
  localparam int unsigned DEF_CNT_W           = 16;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_RATE     = 10000000;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/step_clock_ctrl_if.sv
// step_clock_ctrl_if: board-side signal bundle of the step clock controller.
//   btn_step   : raw STEP pushbutton (async, bouncy)
//   sw_run     : raw RUN switch, 1 = RUN mode
//   step_en    : one-cycle CPU clock-enable pulse
//   run_mode   : debounced sw_run
//   btn_level  : debounced btn_step
//   step_count : number of step_en pulses issued, wraps
// master drives the raw inputs (board / bench), slave is the controller.
interface step_clock_ctrl_if
  import step_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic             btn_step;
  logic             sw_run;
  logic             step_en;
  logic             run_mode;
  logic             btn_level;
  logic [CNT_W-1:0] step_count;

  modport master (
    output btn_step, sw_run,
    input  step_en, run_mode, btn_level, step_count
  );

  modport slave (
    input  btn_step, sw_run,
    output step_en, run_mode, btn_level, step_count
  );
endinterface

// File: rtl/step_clock_ctrl_debounce_sync.sv
// debounce_sync: 2-FF synchronizer followed by a counting debouncer.
//   ssdclk  : board clock
//   rst     : async active-low reset (level and counter cleared)
//   i_raw   : asynchronous raw input
//   o_level : debounced stable level
//   o_flip  : high in the cycle whose clock edge flips o_level
module debounce_sync
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic ssdclk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_flip
);
  localparam int unsigned W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] CNT_LAST = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] CNT_ONE  = W'(1);

  logic         r_meta;
  logic         r_sync;
  logic         r_level;
  logic [W-1:0] r_cnt;
  logic         w_diff;

  assign w_diff  = r_sync ^ r_level;
  assign o_flip  = w_diff & (r_cnt == CNT_LAST);
  assign o_level = r_level;

  always_ff @(posedge ssdclk or negedge rst) begin
    if (!rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (o_flip) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end
endmodule

// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl: debounced STEP/RUN front end producing the CPU clock enable.
//   ssdclk : free-running board clock
//   rst    : async active-low reset
//   bus    : step_clock_ctrl_if.slave (raw btn_step/sw_run in; step_en,
//            run_mode, btn_level, step_count out)
// Optional feature macro: STEP_HOLD_REPEAT_EN adds hold-to-auto-repeat in
// STEP mode (REPEAT state plus a delay/rate down-counter).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a debounced button press (also forced in RUN)
// PRESSED | pulse issued, waiting for release (or hold timeout)
// REPEAT  | held past REPEAT_DELAY, pulsing every REPEAT_RATE cycles
module step_clock_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RUN_DIV         = DEF_RUN_DIV,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic             ssdclk,
  input  logic             rst,
  step_clock_ctrl_if.slave bus
);
  localparam int unsigned DIV_W = cnt_width(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  if (DEBOUNCE_CYCLES < 1 || RUN_DIV < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("step_clock_ctrl: DEBOUNCE_CYCLES, RUN_DIV, REPEAT_DELAY, REPEAT_RATE must be >= 1");
  end

  logic             w_btn_level;
  logic             w_btn_flip;
  logic             w_run_level;
  logic             w_run_flip;
  logic             r_btn_rise;
  logic [DIV_W-1:0] r_div;
  logic             r_step_en;
  logic [CNT_W-1:0] r_count;
  step_state_t      r_state;
  step_state_t      w_state_nxt;
  logic             w_pulse;

`ifdef STEP_HOLD_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = cnt_width(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
  logic [RPT_W-1:0] r_rpt_tmr;
  logic [RPT_W-1:0] w_tmr_nxt;
`endif

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_btn (
    .ssdclk  (ssdclk),
    .rst     (rst),
    .i_raw   (bus.btn_step),
    .o_level (w_btn_level),
    .o_flip  (w_btn_flip)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
    .ssdclk  (ssdclk),
    .rst     (rst),
    .i_raw   (bus.sw_run),
    .o_level (w_run_level),
    .o_flip  (w_run_flip)
  );

  // A run-mode flip this cycle is the mode change: it suppresses any pulse
  // and parks the FSM, whichever direction the switch moved.
  always_comb begin
    w_state_nxt = r_state;
    w_pulse     = 1'b0;
`ifdef STEP_HOLD_REPEAT_EN
    w_tmr_nxt   = r_rpt_tmr;
`endif
    if (w_run_flip) begin
      w_state_nxt = IDLE;
    end else if (w_run_level) begin
      w_state_nxt = IDLE;
      w_pulse     = (r_div == DIV_LAST);
    end else begin
      case (r_state)
        IDLE: begin
          if (r_btn_rise) begin
            w_state_nxt = PRESSED;
            w_pulse     = 1'b1;
`ifdef STEP_HOLD_REPEAT_EN
            w_tmr_nxt   = DELAY_LAST;
`endif
          end
        end
        PRESSED: begin
          if (!w_btn_level) begin
            w_state_nxt = IDLE;
          end
`ifdef STEP_HOLD_REPEAT_EN
          else if (r_rpt_tmr == '0) begin
            w_state_nxt = REPEAT;
            w_tmr_nxt   = RATE_LAST;
          end else begin
            w_tmr_nxt = r_rpt_tmr - RPT_ONE;
          end
`endif
        end
`ifdef STEP_HOLD_REPEAT_EN
        REPEAT: begin
          if (!w_btn_level) begin
            w_state_nxt = IDLE;
          end else if (r_rpt_tmr == '0) begin
            w_pulse   = 1'b1;
            w_tmr_nxt = RATE_LAST;
          end else begin
            w_tmr_nxt = r_rpt_tmr - RPT_ONE;
          end
        end
`endif
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge ssdclk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_step_en  <= 1'b0;
      r_count    <= '0;
      r_div      <= '0;
      r_btn_rise <= 1'b0;
`ifdef STEP_HOLD_REPEAT_EN
      r_rpt_tmr  <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_step_en  <= w_pulse;
      r_count    <= r_count + CNT_W'(w_pulse);
      r_btn_rise <= w_btn_flip & ~w_btn_level;
`ifdef STEP_HOLD_REPEAT_EN
      r_rpt_tmr  <= w_tmr_nxt;
`endif
      if (!w_run_level || w_run_flip || r_div == DIV_LAST) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DIV_ONE;
      end
    end
  end

  assign bus.step_en    = r_step_en;
  assign bus.run_mode   = w_run_level;
  assign bus.btn_level  = w_btn_level;
  assign bus.step_count = r_count;
endmodule

// File: tb/tb_step_clock_ctrl.sv
module tb_step_clock_ctrl;
  localparam int D    = 4;
  localparam int RDIV = 8;
  localparam int CW   = 4;
  localparam int RDLY = 10;
  localparam int RRAT = 3;
  localparam int HN   = 4096;

  logic ssdclk = 1'b0;
  logic rst    = 1'b0;
  always #5 ssdclk = ~ssdclk;

  step_clock_ctrl_if #(.CNT_W(CW)) bus ();

  step_clock_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .RUN_DIV         (RDIV),
    .CNT_W           (CW),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_RATE     (RRAT)
  ) dut (
    .ssdclk (ssdclk),
    .rst    (rst),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // reference model: raw input history since reset, plus spec-level state
  logic raw_b [HN];
  logic raw_s [HN];
  int   n;
  logic m_btn_lvl, m_run_lvl, m_rose_prev, m_hold, m_en;
  int   m_btn_lf, m_run_lf, m_run_rise, m_press;
  logic [CW-1:0] m_cnt;
  int   seen, last_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic logic raw_at(input logic which, input int i);
    if (i < 1 || i >= HN) return 1'b0;
    return which ? raw_s[i] : raw_b[i];
  endfunction

  // level flips at edge e when the synced samples seen at the last D edges
  // (all after the previous flip) differ from the current level
  function automatic logic deb_flip(input logic which, input logic lvl, input int lf, input int e);
    logic f;
    f = 1'b1;
    for (int k = 0; k < D; k++) begin
      if (e - k <= lf) f = 1'b0;
      else if (raw_at(which, e - k - 2) == lvl) f = 1'b0;
    end
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < HN; i++) begin
      raw_b[i] = 1'b0;
      raw_s[i] = 1'b0;
    end
    n = 0;
    m_btn_lvl = 0; m_run_lvl = 0; m_rose_prev = 0; m_hold = 0; m_en = 0;
    m_btn_lf = 0; m_run_lf = 0; m_run_rise = 0; m_press = 0;
    m_cnt = '0;
  endtask

  task automatic model_edge();
    logic rf, bf, pulse;
    rf = deb_flip(1'b1, m_run_lvl, m_run_lf, n);
    bf = deb_flip(1'b0, m_btn_lvl, m_btn_lf, n);
    pulse = 1'b0;
    if (m_hold && (!m_btn_lvl || m_run_lvl || rf)) m_hold = 1'b0;
    if (!rf) begin
      if (m_run_lvl) pulse = ((n - m_run_rise) % RDIV == 0);
      else if (m_rose_prev) begin
        pulse = 1'b1;
        m_hold = 1'b1;
        m_press = n;
      end
`ifdef STEP_HOLD_REPEAT_EN
      else if (m_hold && (n - m_press) > RDLY && ((n - m_press - RDLY) % RRAT == 0))
        pulse = 1'b1;
`endif
    end
    m_rose_prev = bf && !m_btn_lvl;
    if (bf) begin
      m_btn_lvl = !m_btn_lvl;
      m_btn_lf = n;
    end
    if (rf) begin
      m_run_lvl = !m_run_lvl;
      m_run_lf = n;
      if (m_run_lvl) m_run_rise = n;
    end
    m_en = pulse;
    if (pulse) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic tick(input logic b, input logic s);
    bus.btn_step = b;
    bus.sw_run   = s;
    @(posedge ssdclk);
    n++;
    if (n < HN) begin
      raw_b[n] = b;
      raw_s[n] = s;
    end
    model_edge();
    #1;
    chk("step_en",    32'(bus.step_en),    32'(m_en));
    chk("run_mode",   32'(bus.run_mode),   32'(m_run_lvl));
    chk("btn_level",  32'(bus.btn_level),  32'(m_btn_lvl));
    chk("step_count", 32'(bus.step_count), 32'(m_cnt));
    if (bus.step_en === 1'b1) begin
      seen++;
      last_seen = n;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_step_en",    32'(bus.step_en),    0);
    chk("rst_run_mode",   32'(bus.run_mode),   0);
    chk("rst_btn_level",  32'(bus.btn_level),  0);
    chk("rst_step_count", 32'(bus.step_count), 0);
    @(posedge ssdclk);
    #1;
    chk("rst_step_en_hold",    32'(bus.step_en),    0);
    chk("rst_step_count_hold", 32'(bus.step_count), 0);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic rb, rs;
    int bc, sc;
    bus.btn_step = 1'b0;
    bus.sw_run   = 1'b0;
    model_reset();
    repeat (3) @(posedge ssdclk);
    #1;
    do_reset();

    // clean press
    seen = 0; n0 = n;
    repeat (20) tick(1'b1, 1'b0);
    chk("press_pulses",  seen, 1);
    chk("press_latency", last_seen - n0, D + 3);
    chk("press_count",   32'(bus.step_count), 1);
    chk("press_level",   32'(bus.btn_level), 1);
    repeat (10) tick(1'b0, 1'b0);

    // bounce
    seen = 0;
    repeat (3) tick(1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0);
    repeat (2) tick(1'b1, 1'b0);
    repeat (15) tick(1'b0, 1'b0);
    chk("bounce_pulses", seen, 0);
    chk("bounce_count",  32'(bus.step_count), 1);

    // run mode, button held partway through
    seen = 0; n0 = n;
    for (int i = 1; i <= 46; i++) begin
      tick(i >= 20, 1'b1);
      if (i == 5) chk("run_mode_pre",  32'(bus.run_mode), 0);
      if (i == 6) chk("run_mode_rise", 32'(bus.run_mode), 1);
    end
    chk("run_pulses", seen, 5);
    chk("run_first",  last_seen - n0, 6 + 5 * RDIV);
    chk("run_count",  32'(bus.step_count), 6);
    seen = 0;
    repeat (10) tick(1'b1, 1'b0);
    repeat (20) tick(1'b0, 1'b0);
    chk("held_switch_pulses", seen, 0);

    // reset mid-debounce
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    bus.btn_step = 1'b1;
    do_reset();
    seen = 0;
    repeat (12) tick(1'b1, 1'b0);
    chk("rst_mid_pulses",  seen, 1);
    chk("rst_mid_latency", last_seen, D + 3);
    repeat (8) tick(1'b0, 1'b0);

    // wrap
    do_reset();
    for (int p = 1; p <= 17; p++) begin
      repeat (8) tick(1'b1, 1'b0);
      repeat (8) tick(1'b0, 1'b0);
      if (p == 15) chk("wrap_15", 32'(bus.step_count), 15);
      if (p == 16) chk("wrap_0",  32'(bus.step_count), 0);
      if (p == 17) chk("wrap_1",  32'(bus.step_count), 1);
    end

    // long hold
    seen = 0;
    repeat (40) tick(1'b1, 1'b0);
`ifdef STEP_HOLD_REPEAT_EN
    chk("hold_pulses", seen, 8);
`else
    chk("hold_pulses", seen, 1);
`endif
    repeat (10) tick(1'b0, 1'b0);
    seen = 0;
    repeat (10) tick(1'b0, 1'b0);
    chk("release_pulses", seen, 0);

    // randomized bouncy button and switch against the model
    rb = 0; rs = 0; bc = 0; sc = 0;
    for (int i = 0; i < 600; i++) begin
      if (bc == 0) begin
        rb = 1'($urandom_range(0, 1));
        bc = $urandom_range(1, 12);
      end
      if (sc == 0) begin
        rs = 1'($urandom_range(0, 1));
        sc = $urandom_range(1, 70);
      end
      bc--;
      sc--;
      tick(rb, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
